// File: rtl/systolic_feeder_2x2.sv
// rtl/systolic_feeder_2x2.sv - operand feeder and result capture for a 2x2 systolic multiply array
//
// Accepts one 2x2 matrix pair per job, clears the external array, streams
// skewed operands into its row/column inputs, then captures the four
// accumulators as C = A x B and holds them until consumed.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  job handshake (ready only while idle)
//   a_mat, b_mat        operands, [31:0]=x00 [63:32]=x01 [95:64]=x10 [127:96]=x11
//   arr_clr             array accumulator clear
//   fa0, fa1            row-0 / row-1 A streams into the array
//   fb0, fb1            column-0 / column-1 B streams into the array
//   c00..c11            array accumulator outputs
//   out_valid, out_ready result handshake
//   c_mat               captured result, same packing as a_mat
//   busy                high whenever a job is in progress

module systolic_feeder_2x2 (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] a_mat,
  input  logic [127:0] b_mat,
  output logic         arr_clr,
  output logic [31:0]  fa0,
  output logic [31:0]  fa1,
  output logic [31:0]  fb0,
  output logic [31:0]  fb1,
  input  logic [31:0]  c00,
  input  logic [31:0]  c01,
  input  logic [31:0]  c10,
  input  logic [31:0]  c11,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] c_mat,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, CLR, FEED, CAPT, DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_s;
  logic [1:0]   w_s_nxt;
  logic         w_accept;

  logic [127:0] r_a;
  logic [127:0] r_b;
  logic [127:0] r_c;

  logic         r_in_ready;
  logic         r_arr_clr;
  logic         r_busy;
  logic         r_out_valid;
  logic [31:0]  r_fa0, r_fa1, r_fb0, r_fb1;
  logic [31:0]  w_fa0, w_fa1, w_fb0, w_fb1;

  logic [31:0]  w_a00, w_a01, w_a10, w_a11;
  logic [31:0]  w_b00, w_b01, w_b10, w_b11;

  assign w_a00 = r_a[31:0];
  assign w_a01 = r_a[63:32];
  assign w_a10 = r_a[95:64];
  assign w_a11 = r_a[127:96];
  assign w_b00 = r_b[31:0];
  assign w_b01 = r_b[63:32];
  assign w_b10 = r_b[95:64];
  assign w_b11 = r_b[127:96];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CLR;
          w_s_nxt     = 2'd0;
        end
      end
      CLR: begin
        w_state_nxt = FEED;
        w_s_nxt     = 2'd0;
      end
      FEED: begin
        if (r_s == 2'd3) begin
          w_state_nxt = CAPT;
          w_s_nxt     = 2'd0;
        end else begin
          w_s_nxt = r_s + 2'd1;
        end
      end
      CAPT: w_state_nxt = DONE;
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_s_nxt     = 2'd0;
      end
    endcase
  end

  // Feed values for the upcoming cycle. Row 1 / column 1 lag row 0 /
  // column 0 by one step so each PE sees matching k indices as operands
  // ripple right (A) and down (B) through the array.
  always_comb begin
    w_fa0 = 32'd0;
    w_fa1 = 32'd0;
    w_fb0 = 32'd0;
    w_fb1 = 32'd0;
    if (w_state_nxt == FEED) begin
      case (w_s_nxt)
        2'd0: begin
          w_fa0 = w_a00;
          w_fb0 = w_b00;
        end
        2'd1: begin
          w_fa0 = w_a01;
          w_fb0 = w_b10;
          w_fa1 = w_a10;
          w_fb1 = w_b01;
        end
        2'd2: begin
          w_fa1 = w_a11;
          w_fb1 = w_b11;
        end
        default: begin
          w_fa0 = 32'd0;
        end
      endcase
    end
  end

  // All outputs are registered from the next state so they change only at
  // clock edges and line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_in_ready  <= 1'b1;
      r_arr_clr   <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_fa0       <= 32'd0;
      r_fa1       <= 32'd0;
      r_fb0       <= 32'd0;
      r_fb1       <= 32'd0;
    end else begin
      if (w_accept) begin
        r_a <= a_mat;
        r_b <= b_mat;
      end
      // The last products land in the accumulators at the edge closing
      // FEED step 3, so the array outputs are settled throughout CAPT.
      if (r_state == CAPT) begin
        r_c <= {c11, c10, c01, c00};
      end
      r_in_ready  <= (w_state_nxt == IDLE);
      r_arr_clr   <= (w_state_nxt == CLR);
      r_busy      <= (w_state_nxt != IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_fa0       <= w_fa0;
      r_fa1       <= w_fa1;
      r_fb0       <= w_fb0;
      r_fb1       <= w_fb1;
    end
  end

  assign in_ready  = r_in_ready;
  assign arr_clr   = r_arr_clr;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign fa0       = r_fa0;
  assign fa1       = r_fa1;
  assign fb0       = r_fb0;
  assign fb1       = r_fb1;
  assign c_mat     = r_c;

endmodule
